// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 7-segment scan-bus receiver.
// Segment codes match the display driver's encode table.
package seven_seg_pkg;

  localparam logic [6:0] SEG_CODE [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  localparam logic [3:0] AN_DIGIT [0:3] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  localparam logic [3:0] AN_BLANK = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    EVAL,
    HOLD
  } scan_state_t;

  function automatic logic multi_low(input logic [3:0] an);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) zeros++;
    end
    return zeros > 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_decode.sv
// Combinational active-low segment pattern to BCD decoder.
// Any pattern outside the ten digit codes reports legal=0.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic       legal,
  output logic [3:0] bcd
);

  always_comb begin
    legal = 1'b0;
    bcd   = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (seg_n == SEG_CODE[i]) begin
        legal = 1'b1;
        bcd   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Scan-bus receiver: synchronize, wait for a settled dwell,
// decode the segments and rebuild the four displayed digits.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  an_n,
  input  logic [6:0]  seg_n,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        pat_err,
  output logic        an_err,
  output logic        stale
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] S_MAX = CW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

  logic [10:0] sync_q [SYNC_STAGES];
  logic [3:0]  s_an;
  logic [6:0]  s_seg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '1;
    end else begin
      sync_q[0] <= {an_n, seg_n};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign {s_an, s_seg} = sync_q[SYNC_STAGES-1];

  logic [10:0]   prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          changed;
  logic          blank;

  assign changed = {s_an, s_seg} != prev_q;
  assign blank   = s_an == AN_BLANK;

  always_comb begin
    cnt_d = cnt_q;
    if (changed)
      cnt_d = CW'(1);
    else if (cnt_q != S_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q <= '1;
      cnt_q  <= '0;
    end else begin
      prev_q <= {s_an, s_seg};
      cnt_q  <= cnt_d;
    end
  end

  scan_state_t state_q;
  scan_state_t state_d;

  // SETTLE looks at cnt_d so EVAL lands on the cycle the count completes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (!blank) state_d = SETTLE;
      SETTLE: begin
        if (blank)
          state_d = IDLE;
        else if (cnt_d == S_MAX)
          state_d = EVAL;
      end
      EVAL:   state_d = HOLD;
      HOLD:   if (changed) state_d = blank ? IDLE : SETTLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  logic       an_one;
  logic [1:0] an_idx;

  always_comb begin
    an_one = 1'b0;
    an_idx = 2'd0;
    unique case (1'b1)
      (s_an == AN_DIGIT[0]): begin an_one = 1'b1; an_idx = 2'd0; end
      (s_an == AN_DIGIT[1]): begin an_one = 1'b1; an_idx = 2'd1; end
      (s_an == AN_DIGIT[2]): begin an_one = 1'b1; an_idx = 2'd2; end
      (s_an == AN_DIGIT[3]): begin an_one = 1'b1; an_idx = 2'd3; end
      default: ;
    endcase
  end

  logic       legal;
  logic [3:0] bcd;

  seg_pattern_decode u_decode (
    .seg_n (s_seg),
    .legal (legal),
    .bcd   (bcd)
  );

  logic          in_eval;
  logic          cap;
  logic [3:0]    seen_q;
  logic [3:0]    seen_cap;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
  logic          t_hit;

  assign in_eval  = state_q == EVAL;
  assign cap      = in_eval && an_one && legal;
  assign seen_cap = seen_q | (4'b0001 << an_idx);

  always_comb begin
    tcnt_d = tcnt_q;
    if (cap)
      tcnt_d = '0;
    else if (tcnt_q != T_MAX)
      tcnt_d = tcnt_q + 1'b1;
  end

  // a capture in the same cycle as the limit wins
  assign t_hit = !cap && !stale && (tcnt_d == T_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digits      <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      pat_err     <= 1'b0;
      an_err      <= 1'b0;
      stale       <= 1'b0;
      seen_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      frame_done <= 1'b0;
      pat_err    <= in_eval && an_one && !legal;
      an_err     <= in_eval && multi_low(s_an);
      tcnt_q     <= tcnt_d;
      if (cap) begin
        digits[{an_idx, 2'b00} +: 4] <= bcd;
        digit_valid[an_idx]          <= 1'b1;
        stale                        <= 1'b0;
        if (seen_cap == 4'hF) begin
          frame_done <= 1'b1;
          seen_q     <= '0;
        end else begin
          seen_q <= seen_cap;
        end
      end else if (t_hit) begin
        stale       <= 1'b1;
        digit_valid <= '0;
        seen_q      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: dwell vector table with a
// scoreboard queue, plus latency, glitch, timeout and reset sequences.
module tb_seven_seg_scan_decoder;

  localparam int DWELL = 24;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  an_n  = 4'hF;
  logic [6:0]  seg_n = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        pat_err;
  logic        an_err;
  logic        stale;

  seven_seg_scan_decoder #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (64),
    .SYNC_STAGES    (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .pat_err     (pat_err),
    .an_err      (an_err),
    .stale       (stale)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_fd = 0;
  int n_pe = 0;
  int n_ae = 0;

  always @(negedge clock) begin
    if (frame_done) n_fd++;
    if (pat_err)    n_pe++;
    if (an_err)     n_ae++;
  end

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  valid;
    int          fd;
    int          pe;
    int          ae;
  } vec_t;

  logic [6:0] code [0:9];
  vec_t       vecs [19];
  vec_t       sb [$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int   fd0, pe0, ae0;
    string tag;
    fd0   = n_fd;
    pe0   = n_pe;
    ae0   = n_ae;
    an_n  = v.an;
    seg_n = v.seg;
    sb.push_back(v);
    repeat (DWELL) @(negedge clock);
    e   = sb.pop_front();
    tag = $sformatf("vec%0d", idx);
    check({tag, "_digits"}, 32'(digits), 32'(e.digits));
    check({tag, "_valid"}, 32'(digit_valid), 32'(e.valid));
    check({tag, "_frame"}, n_fd - fd0, e.fd);
    check({tag, "_paterr"}, n_pe - pe0, e.pe);
    check({tag, "_anerr"}, n_ae - ae0, e.ae);
  endtask

  initial begin
    int lat, st, fd0, pe0, ae0;
    logic ok;
    logic [6:0] g;

    code = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
             7'b0000000, 7'b0000100};

    vecs[0]  = '{4'b1110, code[4], 16'h0004, 4'h1, 0, 0, 0};
    vecs[1]  = '{4'b1101, code[3], 16'h0034, 4'h3, 0, 0, 0};
    vecs[2]  = '{4'b1011, code[2], 16'h0234, 4'h7, 0, 0, 0};
    vecs[3]  = '{4'b0111, code[1], 16'h1234, 4'hF, 1, 0, 0};
    vecs[4]  = '{4'b1110, code[4], 16'h1234, 4'hF, 0, 0, 0};
    vecs[5]  = '{4'b1101, code[3], 16'h1234, 4'hF, 0, 0, 0};
    vecs[6]  = '{4'b1011, code[2], 16'h1234, 4'hF, 0, 0, 0};
    vecs[7]  = '{4'b0111, code[1], 16'h1234, 4'hF, 1, 0, 0};
    vecs[8]  = '{4'b1110, 7'b0110000, 16'h1234, 4'hF, 0, 1, 0};
    vecs[9]  = '{4'b1110, code[9], 16'h1239, 4'hF, 0, 0, 0};
    vecs[10] = '{4'b1100, code[8], 16'h1239, 4'hF, 0, 0, 1};
    vecs[11] = '{4'b1101, code[0], 16'h1209, 4'hF, 0, 0, 0};
    vecs[12] = '{4'b1111, code[8], 16'h1209, 4'hF, 0, 0, 0};
    vecs[13] = '{4'b1011, code[7], 16'h1709, 4'hF, 0, 0, 0};
    vecs[14] = '{4'b1101, code[8], 16'h1789, 4'hF, 0, 0, 0};
    vecs[15] = '{4'b0111, code[6], 16'h6789, 4'hF, 1, 0, 0};
    vecs[16] = '{4'b1110, code[4], 16'h6784, 4'hF, 0, 0, 0};
    vecs[17] = '{4'b1011, code[2], 16'h6284, 4'hF, 0, 0, 0};
    vecs[18] = '{4'b0111, code[6], 16'h6284, 4'hF, 0, 0, 0};

    repeat (10) begin
      @(negedge clock);
      an_n  = 4'($urandom);
      seg_n = 7'($urandom);
    end
    check("reset_outputs",
          {digits, digit_valid, frame_done, pat_err, an_err, stale}, 0);
    check("reset_pulses", n_fd + n_pe + n_ae, 0);

    an_n  = 4'hF;
    seg_n = 7'h7F;
    @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);
    check("release_outputs",
          {digits, digit_valid, frame_done, pat_err, an_err, stale}, 0);
    check("release_pulses", n_fd + n_pe + n_ae, 0);

    an_n  = 4'b1110;
    seg_n = code[4];
    lat   = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (digit_valid[0]) begin
        lat = i;
        break;
      end
    end
    check("capture_latency", lat, 7);

    for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

    fd0   = n_fd;
    an_n  = 4'b1101;
    seg_n = code[8];
    repeat (20) @(negedge clock);
    check("frame_on_digit1", n_fd - fd0, 1);

    g     = code[8] ^ 7'b0000001;
    seg_n = g;
    repeat (2) @(negedge clock);
    seg_n = code[8];
    ok    = 1'b1;
    st    = 0;
    pe0   = n_pe;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      if (digits[7:4] !== 4'd8) ok = 1'b0;
      if (stale) begin
        st = i;
        break;
      end
    end
    check("glitch_not_captured", 32'(ok), 1);
    check("glitch_no_paterr", n_pe - pe0, 0);
    check("recapture_then_stale", st, 71);
    check("stale_valid", 32'(digit_valid), 0);
    check("stale_digits", 32'(digits), 32'h6284);

    an_n  = 4'b1110;
    seg_n = code[5];
    repeat (12) @(negedge clock);
    check("stale_cleared", 32'(stale), 0);
    check("valid_after_stale", 32'(digit_valid), 32'h1);
    check("digits_after_stale", 32'(digits), 32'h6285);

    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_reset",
          {digits, digit_valid, frame_done, pat_err, an_err, stale}, 0);
    @(negedge clock);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    fd0   = n_fd;
    pe0   = n_pe;
    ae0   = n_ae;
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("rerelease_pulses", (n_fd - fd0) + (n_pe - pe0) + (n_ae - ae0), 0);
    check("rerelease_outputs", {digits, digit_valid, stale}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
